// File: rtl/tm32_if.sv
// Operand/product bundle for the tm32 unsigned 32x32 multiplier.
interface tm32_if;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [63:0] out;

  modport master (output in1, output in2, input out);
  modport slave  (input in1, input in2, output out);
endinterface

// File: rtl/tm32.sv
// 32x32 unsigned tree multiplier: partial-product array, row-wise 3:2 reduction
// down to two rows, then one 64-bit carry-propagate add. Optional output register.
module tm32 #(
  parameter int unsigned PIPELINE = 0
) (
  input  logic   clk,
  input  logic   rst,
  tm32_if.slave  bus
);

  localparam int unsigned LEVELS = 8;

  // Row count after each compression layer: 32,22,15,10,7,5,4,3,2.
  function automatic int unsigned rows_at(input int unsigned lvl);
    int unsigned n;
    n = 32;
    for (int unsigned k = 0; k < lvl; k++) n = (n / 3) * 2 + (n % 3);
    return n;
  endfunction

  logic [63:0] tree [0:LEVELS][0:31];
  logic [63:0] prod;

  genvar i, l, g;

  generate
    for (i = 0; i < 32; i++) begin : g_pp
      assign tree[0][i] = {32'b0, bus.in1 & {32{bus.in2[i]}}} << i;
    end

    for (l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int unsigned N_IN  = rows_at(l);
      localparam int unsigned N_FA  = N_IN / 3;
      localparam int unsigned N_OUT = rows_at(l + 1);

      // Each group of three rows becomes a sum row and a carry row shifted one column left.
      for (g = 0; g < N_FA; g++) begin : g_fa
        logic [63:0] a, b, c;
        assign a = tree[l][3*g];
        assign b = tree[l][3*g+1];
        assign c = tree[l][3*g+2];
        assign tree[l+1][2*g]   = a ^ b ^ c;
        assign tree[l+1][2*g+1] = {(a[62:0] & b[62:0]) | (a[62:0] & c[62:0]) | (b[62:0] & c[62:0]), 1'b0};
      end

      for (g = 0; g < N_IN - 3*N_FA; g++) begin : g_pass
        assign tree[l+1][2*N_FA+g] = tree[l][3*N_FA+g];
      end

      for (g = N_OUT; g < 32; g++) begin : g_zero
        assign tree[l+1][g] = '0;
      end
    end
  endgenerate

  // The true product fits in 64 bits, so carries dropped above bit 63 lose nothing.
  assign prod = tree[LEVELS][0] + tree[LEVELS][1];

  generate
    if (PIPELINE != 0) begin : g_reg
      logic [63:0] q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else      q <= prod;
      end
      assign bus.out = q;
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign bus.out = prod;
    end
  endgenerate

endmodule

// File: tb/tb_tm32.sv
// Self-checking bench for tm32: combinational and registered variants against
// a plain 64-bit arithmetic reference.
module tb_tm32;

  logic clk;
  logic rst;
  logic noise_clk;
  logic noise_rst;

  int unsigned n_checks;
  int unsigned n_errors;

  tm32_if bus_c ();
  tm32_if bus_p ();

  tm32 #(.PIPELINE(0)) dut_comb (.clk(noise_clk), .rst(noise_rst), .bus(bus_c));
  tm32 #(.PIPELINE(1)) dut_pipe (.clk(clk),       .rst(rst),       .bus(bus_p));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa, wb;
    wa = {32'b0, a};
    wb = {32'b0, b};
    return wa * wb;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic comb_vec(input string tag, input logic [31:0] a, input logic [31:0] b);
    bus_c.in1 = a;
    bus_c.in2 = b;
    noise_clk = 1'($urandom);
    noise_rst = 1'($urandom);
    #1;
    check(tag, bus_c.out, ref_mul(a, b));
  endtask

  logic [31:0] ra, rb;
  logic [63:0] exp_p;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    noise_clk = 1'b0;
    noise_rst = 1'b0;
    bus_c.in1 = '0;
    bus_c.in2 = '0;
    bus_p.in1 = 32'd7;
    bus_p.in2 = 32'd9;
    rst       = 1'b1;

    // Registered variant: asynchronous reset before any clock edge.
    #2 rst = 1'b0;
    #1 check("pipe_reset_async", bus_p.out, 64'h0);

    // Inputs ignored while reset is held across edges.
    @(negedge clk);
    bus_p.in1 = 32'hDEADBEEF;
    bus_p.in2 = 32'h12345678;
    @(posedge clk); #1;
    check("pipe_reset_hold", bus_p.out, 64'h0);

    @(negedge clk);
    rst = 1'b1;
    bus_p.in1 = 32'hFFFFFF85;
    bus_p.in2 = 32'd456;
    exp_p = ref_mul(32'hFFFFFF85, 32'd456);
    #1 check("pipe_no_edge_yet", bus_p.out, 64'h0);
    @(posedge clk); #1;
    check("pipe_first_capture", bus_p.out, exp_p);

    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      ra = $urandom;
      rb = $urandom;
      if (k % 8 == 0) ra = 32'hFFFFFFFF;
      if (k % 8 == 4) rb = 32'h0;
      bus_p.in1 = ra;
      bus_p.in2 = rb;
      #1 check("pipe_hold_between_edges", bus_p.out, exp_p);
      exp_p = ref_mul(ra, rb);
      @(posedge clk); #1;
      check("pipe_stream", bus_p.out, exp_p);
    end

    // Reset mid-stream, while clk is high: clears immediately, pending product discarded.
    #1 rst = 1'b0;
    #1 check("pipe_reset_midstream", bus_p.out, 64'h0);
    @(negedge clk);
    bus_p.in1 = 32'hFFFFFFFF;
    bus_p.in2 = 32'hFFFFFFFF;
    @(posedge clk); #1;
    check("pipe_reset_discard", bus_p.out, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("pipe_after_release", bus_p.out, 64'hFFFFFFFE00000001);

    // Combinational variant: directed cases.
    comb_vec("comb_20x15", 32'd20, 32'd15);
    check("comb_20x15_lit", bus_c.out, 64'd300);
    comb_vec("comb_zero_in1", 32'd0, 32'd50);
    check("comb_zero_in1_lit", bus_c.out, 64'd0);
    comb_vec("comb_zero_in2", 32'hCAFEF00D, 32'd0);
    comb_vec("comb_one_in1", 32'd1, 32'd100);
    check("comb_one_in1_lit", bus_c.out, 64'd100);
    comb_vec("comb_one_ext", 32'd1, 32'hFFFFFFFB);
    check("comb_one_ext_lit", bus_c.out, 64'h00000000FFFFFFFB);
    comb_vec("comb_10xfffb", 32'd10, 32'hFFFFFFFB);
    check("comb_10xfffb_lit", bus_c.out, 64'h00000009FFFFFFCE);
    comb_vec("comb_fffbxfffa", 32'hFFFFFFFB, 32'hFFFFFFFA);
    check("comb_fffbxfffa_lit", bus_c.out, 64'hFFFFFFF50000001E);
    comb_vec("comb_ff9cx25", 32'hFFFFFF9C, 32'd25);
    check("comb_ff9cx25_lit", bus_c.out, 64'h00000018FFFFF63C);
    comb_vec("comb_max", 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("comb_max_lit", bus_c.out, 64'hFFFFFFFE00000001);

    for (int k = 0; k < 32; k++) begin
      comb_vec("comb_single_bits", 32'h1 << k, 32'h80000000 >> k);
    end

    for (int k = 0; k < 10000; k++) begin
      ra = $urandom;
      rb = $urandom;
      comb_vec("comb_random", ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
